// File: rtl/demux_1to8_buf.sv
// Registered 1-to-8 demultiplexer: one source word steered into eight single-entry slots,
// each drained by its own valid/ready handshake. Optional macro: DEMUX_1TO8_ZERO_IDLE_EN.
module demux_1to8_buf #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic [2:0]      select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic [size-1:0] data2_o,
  output logic [size-1:0] data3_o,
  output logic [size-1:0] data4_o,
  output logic [size-1:0] data5_o,
  output logic [size-1:0] data6_o,
  output logic [size-1:0] data7_o,
  output logic [7:0]      valid_o,
  input  logic [7:0]      ready_i,
  output logic [3:0]      occ_o
);

  logic [7:0]            f_q;
  logic [7:0]            f_d;
  logic [3:0]            occ_q;
  logic [3:0]            occ_d;
  logic                  accept;
  logic [7:0]            drain;
  logic [7:0]            acc_onehot;
  logic [3:0]            n_drain;
  logic [7:0][size-1:0]  data_w;

  // ready_o never looks at ready_i, so no consumer can reach back to the producer.
  always_comb begin
    ready_o    = ~f_q[select_i];
    accept     = valid_i & ready_o;
    drain      = f_q & ready_i;
    acc_onehot = accept ? (8'b0000_0001 << select_i) : 8'b0000_0000;
    f_d        = (f_q & ~drain) | acc_onehot;
    n_drain    = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n_drain = n_drain + {3'b000, drain[i]};
    end
    occ_d = occ_q + {3'b000, accept} - n_drain;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_q   <= 8'h00;
      occ_q <= 4'd0;
    end else begin
      f_q   <= f_d;
      occ_q <= occ_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      logic [size-1:0] slot_q;
      logic [size-1:0] slot_d;

      always_comb begin
        slot_d = acc_onehot[gi] ? data_i : slot_q;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_d;
        end
      end

`ifdef DEMUX_1TO8_ZERO_IDLE_EN
      // Idle slots read zero so several outputs can be OR-combined onto one bus.
      assign data_w[gi] = f_q[gi] ? slot_q : '0;
`else
      assign data_w[gi] = slot_q;
`endif
    end
  endgenerate

  assign valid_o = f_q;
  assign occ_o   = occ_q;
  assign data0_o = data_w[0];
  assign data1_o = data_w[1];
  assign data2_o = data_w[2];
  assign data3_o = data_w[3];
  assign data4_o = data_w[4];
  assign data5_o = data_w[5];
  assign data6_o = data_w[6];
  assign data7_o = data_w[7];

endmodule

// File: tb/tb_demux_1to8_buf.sv
// Bench for demux_1to8_buf: slot-array reference model checked every cycle, directed
// literal scenarios, then randomized traffic. Honours DEMUX_1TO8_ZERO_IDLE_EN.
`timescale 1ns/100ps
module tb_demux_1to8_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [2:0]  select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] dout [8];
  logic [7:0]  valid_o;
  logic [7:0]  ready_i;
  logic [3:0]  occ_o;

  int checks = 0;
  int errors = 0;

  // Reference model: which slots hold a word, and the last word each slot was given.
  bit          m_full [8];
  logic [31:0] m_data [8];
  bit          m_live = 1'b0;

  always #10 clk_i = ~clk_i;

  demux_1to8_buf #(.size(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (dout[0]),
    .data1_o  (dout[1]),
    .data2_o  (dout[2]),
    .data3_o  (dout[3]),
    .data4_o  (dout[4]),
    .data5_o  (dout[5]),
    .data6_o  (dout[6]),
    .data7_o  (dout[7]),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .occ_o    (occ_o)
  );

  function automatic logic [31:0] exp_data(input int k);
`ifdef DEMUX_1TO8_ZERO_IDLE_EN
    return m_full[k] ? m_data[k] : 32'h0;
`else
    return m_data[k];
`endif
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_occ();
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(m_full[k]);
    return 4'(n);
  endfunction

  // Model update from the inputs present at the rising edge.
  always @(posedge clk_i) begin
    if (rst_i === 1'b1) begin
      for (int k = 0; k < 8; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 32'h0;
      end
      m_live = 1'b1;
    end else if (m_live) begin
      bit acc;
      int s;
      s   = int'(select_i);
      acc = valid_i && !m_full[s];
      for (int k = 0; k < 8; k++) begin
        if (m_full[k] && ready_i[k]) m_full[k] = 1'b0;
      end
      if (acc) begin
        m_full[s] = 1'b1;
        m_data[s] = data_i;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (m_live) begin
      checks++;
      if (valid_o !== exp_valid()) begin
        errors++;
        $display("FAIL model_valid t=%0t got %02h exp %02h", $time, valid_o, exp_valid());
      end
      checks++;
      if (occ_o !== exp_occ()) begin
        errors++;
        $display("FAIL model_occ t=%0t got %0d exp %0d", $time, occ_o, exp_occ());
      end
      checks++;
      if (ready_o !== !m_full[int'(select_i)]) begin
        errors++;
        $display("FAIL model_ready t=%0t sel %0d got %b exp %b", $time, select_i, ready_o,
                 !m_full[int'(select_i)]);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (dout[k] !== exp_data(k)) begin
          errors++;
          $display("FAIL model_data%0d t=%0t got %08h exp %08h", k, $time, dout[k], exp_data(k));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
    valid_i  = v;
    select_i = s;
    data_i   = d;
    ready_i  = r;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", name, got, exp);
    end else begin
      $display("ok   %s = %08h", name, got);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic chk_ready_all(input string name, input bit exp);
    valid_i = 1'b0;
    for (int s = 0; s < 8; s++) begin
      select_i = 3'(s);
      #1;
      chk($sformatf("%s_sel%0d", name, s), {31'h0, ready_o}, {31'h0, exp});
    end
    select_i = 3'd0;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    tick();
    do_reset();

    // Idle state after reset.
    chk("rst_valid", {24'h0, valid_o}, 32'h00);
    chk("rst_occ", {28'h0, occ_o}, 32'h0);
    for (int k = 0; k < 8; k++) chk($sformatf("rst_data%0d", k), dout[k], 32'h0);
    chk_ready_all("rst_ready", 1'b1);

    // Single write to slot 3, then a stalled second write to the same slot.
    drive(1'b1, 3'd3, 32'hA5A5_0003, 8'h00);
    tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("wr3_valid", {24'h0, valid_o}, 32'h08);
    chk("wr3_data", dout[3], 32'hA5A5_0003);
    chk("wr3_occ", {28'h0, occ_o}, 32'h1);
    drive(1'b1, 3'd3, 32'hDEAD_BEEF, 8'h00);
    #1;
    chk("stall3_ready", {31'h0, ready_o}, 32'h0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("stall3_valid", {24'h0, valid_o}, 32'h08);
    chk("stall3_data", dout[3], 32'hA5A5_0003);
    chk("stall3_occ", {28'h0, occ_o}, 32'h1);

    // Fill all eight slots, then drain slots 0 and 7 together.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 32'(k), 8'h00);
      tick();
    end
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("full_valid", {24'h0, valid_o}, 32'hFF);
    chk("full_occ", {28'h0, occ_o}, 32'h8);
    chk("full_data6", dout[6], 32'h6);
    chk_ready_all("full_ready", 1'b0);
    drive(1'b0, 3'd0, 32'h0, 8'h81);
    tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("drain81_valid", {24'h0, valid_o}, 32'h7E);
    chk("drain81_occ", {28'h0, occ_o}, 32'h6);

    // Accept to slot 2 while slots 5 and 6 drain.
    do_reset();
    drive(1'b1, 3'd5, 32'h55, 8'h00); tick();
    drive(1'b1, 3'd6, 32'h66, 8'h00); tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("pre_mix_occ", {28'h0, occ_o}, 32'h2);
    drive(1'b1, 3'd2, 32'h22, 8'h60);
    tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("mix_occ", {28'h0, occ_o}, 32'h1);
    chk("mix_valid", {24'h0, valid_o}, 32'h04);
    chk("mix_data2", dout[2], 32'h22);

    // Reset wins over a simultaneous accept.
    do_reset();
    drive(1'b1, 3'd1, 32'h11, 8'h00); tick();
    drive(1'b1, 3'd4, 32'h44, 8'h00); tick();
    drive(1'b1, 3'd0, 32'h99, 8'h00);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("rstmid_valid", {24'h0, valid_o}, 32'h00);
    chk("rstmid_occ", {28'h0, occ_o}, 32'h0);
    chk("rstmid_data0", dout[0], 32'h0);

    // Idle value of a drained slot depends on the build.
    drive(1'b1, 3'd1, 32'h1234, 8'h00); tick();
    drive(1'b0, 3'd0, 32'h0, 8'h02); tick();
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    chk("idle1_valid", {24'h0, valid_o}, 32'h00);
`ifdef DEMUX_1TO8_ZERO_IDLE_EN
    chk("idle1_data", dout[1], 32'h0);
`else
    chk("idle1_data", dout[1], 32'h1234);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      drive(1'(($urandom_range(0, 3) != 0)), 3'($urandom_range(0, 7)), $urandom(),
            8'($urandom() & $urandom()));
      tick();
    end
    rst_i = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 8'h00);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to8_buf.md
# demux_1to8_buf

Registered 1-to-8 demultiplexer. It is the write-side counterpart of the 8-to-1 select mux in the pipeline datapath. A single source word, tagged with a 3-bit destination select, is steered into one of eight single-entry holding slots. Each slot drains independently through its own valid/ready handshake. Result fan-out points and multi-consumer stages use it where one producer must feed eight consumers without combinational paths from any consumer back to the producer.

## Interface
Parameters:
- size, 32, data width in bits; legal range 1–64.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- data_i  input  size  source word.
- select_i  input  3  destination slot index, 0–7.
- valid_i  input  1  source word and select are valid this cycle.
- ready_o  output  1  the slot addressed by select_i can accept; combinational from select_i and slot state.
- data0_o … data7_o  output  size each  slot k held word.
- valid_o  output  8  bit k set when slot k holds a word.
- ready_i  input  8  bit k set when consumer k takes slot k this cycle.
- occ_o  output  4  number of occupied slots, 0–8.

## Operation
- Each slot k has a data register D[k] and a full flag F[k].
  - valid_o[k] = F[k].
  - dataK_o = D[k], subject to the Configuration section.
- ready_o = ~F[select_i].
  - ready_o does not depend on any ready_i bit. There is no same-cycle pass-through.
- Accept: valid_i & ready_o at an edge. Then D[select_i] ← data_i and F[select_i] ← 1.
- Drain: F[k] & ready_i[k] at an edge. Then F[k] ← 0. D[k] is unchanged except under the Configuration macro.
- Accept to slot j and drain of slot k ≠ j in the same cycle: both take effect.
- Accept and drain of the same slot in the same cycle cannot occur, because ready_o is 0 when that slot is full.
- Drains on several slots in the same cycle: all take effect.
- valid_i with select_i pointing to a full slot: no accept, no state change. The source must hold data_i, select_i and valid_i until ready_o = 1.
  - The source may change select_i while stalled. ready_o tracks the new select combinationally.
- ready_i[k] while F[k] = 0: ignored.
- occ_o is a registered count.
  - Next value = occ + accept − (number of drains).
  - Range is 0–8, so 4 bits cannot wrap.
  - occ_o always equals popcount(valid_o) after every edge.
- Slots are independent. There is no ordering guarantee across slots. Each slot holds at most one word.

## Timing
- Reset: when rst_i = 1 at an edge, all F ← 0, occ_o ← 0, and all D ← 0.
  - After reset: valid_o = 8'h00, all dataK_o = 0, occ_o = 0.
  - ready_o = 1 for any select_i.
- Reset mid-operation takes priority over a simultaneous accept or drain. Held words are discarded.
- Latency: a word accepted at edge N is visible on dataK_o with valid_o[k] = 1 after edge N.
- Minimum per-slot period is 2 cycles: accept, then drain.
- Aggregate throughput is one accept per cycle while the addressed slots are empty.
- Holding: D[k] and F[k] are stable while F[k] = 1 and ready_i[k] = 0.
- The only combinational path is select_i and F → ready_o. All other outputs come directly from registers.

## Configuration
- Macro: DEMUX_1TO8_ZERO_IDLE_EN.
- When defined, dataK_o = F[k] ? D[k] : 0. Idle outputs read zero, which is useful for OR-combined buses.
- When not defined, dataK_o = D[k] always. An idle slot shows the last word it held, or 0 if it has held nothing since reset.
- Handshake, occupancy and reset behaviour are identical in both builds.

## Test plan
- Reset, then check idle outputs → valid_o = 00, occ_o = 0, ready_o = 1 for every select value 0–7, all data outputs = 0.
- Write 32'hA5A5_0003 to select 3 with ready_i = 0 → next cycle valid_o = 08, data3_o = A5A5_0003, occ_o = 1.
  - Then drive select 3 again → ready_o = 0 and no change after the edge.
- Fill all slots with data_i = k at select k over cycles 0–7, ready_i = 0 → valid_o = FF, occ_o = 8, ready_o = 0 for every select.
  - Then ready_i = 8'h81 → valid_o = 7E, occ_o = 6.
- Accept to slot 2 while draining slots 5 and 6 in the same cycle, starting from occ_o = 2 → occ_o = 1, valid_o = 04.
- Assert rst_i while slots 1 and 4 are full and valid_i targets slot 0 → valid_o = 00, occ_o = 0, no accept.
- Drain slot 1 after it held 32'h1234, once per build → data1_o = 0 with DEMUX_1TO8_ZERO_IDLE_EN, data1_o = 32'h1234 without it.
